// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-entry skid-less stage with operand forwarding,
// load-use hazard detection, held-entry operand refresh and a stall counter.
module id_ex_stage #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rstn,

    input  logic            in_valid,
    output logic            in_ready,

    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [RA_W-1:0] rs1_addr,
    input  logic [RA_W-1:0] rs2_addr,
    input  logic [RA_W-1:0] rd_addr,
    input  logic [3:0]      alu_op,
    input  logic            a_sel,
    input  logic            b_sel,
    input  logic            uses_rs1,
    input  logic            uses_rs2,
    input  logic            reg_we,
    input  logic            is_load,

    input  logic            ex_fwd_valid,
    input  logic [RA_W-1:0] ex_fwd_rd,
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            ex_fwd_is_load,
    input  logic            wb_fwd_valid,
    input  logic [RA_W-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,

    input  logic            flush,

    output logic            out_valid,
    input  logic            out_ready,

    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op_out,
    output logic [RA_W-1:0] rd_out,
    output logic            reg_we_out,
    output logic            is_load_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] store_data,

    output logic [15:0]     stall_cnt
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned CNT_W = 16;
    localparam logic [OP_W-1:0] ALU_DEFAULT = 4'h0;

    // Operand source selection: EX (non-load) beats WB beats register file; x0 never forwards.
    function automatic logic [XLEN-1:0] resolve(
        input logic [RA_W-1:0] addr,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_v,
        input logic [RA_W-1:0] ex_rd,
        input logic [XLEN-1:0] ex_d,
        input logic            ex_ld,
        input logic            wb_v,
        input logic [RA_W-1:0] wb_rd,
        input logic [XLEN-1:0] wb_d
    );
        logic [XLEN-1:0] r;
        r = rf_val;
        if (ex_v && !ex_ld && (ex_rd != '0) && (ex_rd == addr)) begin
            r = ex_d;
        end else if (wb_v && (wb_rd != '0) && (wb_rd == addr)) begin
            r = wb_d;
        end
        return r;
    endfunction

    logic            valid_q,    valid_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic [XLEN-1:0] rs1_q,      rs1_d;
    logic [XLEN-1:0] rs2_q,      rs2_d;
    logic [RA_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [RA_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [RA_W-1:0] rd_q,       rd_d;
    logic [OP_W-1:0] op_q,       op_d;
    logic            a_sel_q,    a_sel_d;
    logic            b_sel_q,    b_sel_d;
    logic            reg_we_q,   reg_we_d;
    logic            is_load_q,  is_load_d;
    logic [CNT_W-1:0] stall_q,   stall_d;

    logic            hazard;
    logic            xfer;
    logic            hold;
    logic [XLEN-1:0] rs1_new;
    logic [XLEN-1:0] rs2_new;
    logic [XLEN-1:0] rs1_ref;
    logic [XLEN-1:0] rs2_ref;

    // Load in EX whose result the incoming instruction needs cannot be forwarded yet.
    always_comb begin
        hazard = 1'b0;
        if (ex_fwd_valid && ex_fwd_is_load && (ex_fwd_rd != '0)) begin
            hazard = (uses_rs1 && (ex_fwd_rd == rs1_addr)) ||
                     (uses_rs2 && (ex_fwd_rd == rs2_addr));
        end
    end

    assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
    assign xfer     = in_valid && in_ready;
    assign hold     = valid_q && !out_ready && !flush;

    always_comb begin
        rs1_new = resolve(rs1_addr, rs1_data, ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                          ex_fwd_is_load, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
        rs2_new = resolve(rs2_addr, rs2_data, ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                          ex_fwd_is_load, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
        rs1_ref = resolve(rs1_addr_q, rs1_q, ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                          ex_fwd_is_load, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
        rs2_ref = resolve(rs2_addr_q, rs2_q, ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                          ex_fwd_is_load, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
    end

    // Next-state: capture on transfer, refresh operands of a held entry, else keep.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_d       = rd_q;
        op_d       = op_q;
        a_sel_d    = a_sel_q;
        b_sel_d    = b_sel_q;
        reg_we_d   = reg_we_q;
        is_load_d  = is_load_q;
        stall_d    = stall_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (xfer) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        if (xfer) begin
            pc_d       = pc;
            imm_d      = imm;
            rs1_d      = rs1_new;
            rs2_d      = rs2_new;
            rs1_addr_d = rs1_addr;
            rs2_addr_d = rs2_addr;
            rd_d       = rd_addr;
            op_d       = alu_op;
            a_sel_d    = a_sel;
            b_sel_d    = b_sel;
            reg_we_d   = reg_we;
            is_load_d  = is_load;
        end else if (hold) begin
            rs1_d = rs1_ref;
            rs2_d = rs2_ref;
        end

        if (in_valid && hazard && !flush && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_q       <= '0;
            op_q       <= ALU_DEFAULT;
            a_sel_q    <= 1'b0;
            b_sel_q    <= 1'b0;
            reg_we_q   <= 1'b0;
            is_load_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_q       <= rd_d;
            op_q       <= op_d;
            a_sel_q    <= a_sel_d;
            b_sel_q    <= b_sel_d;
            reg_we_q   <= reg_we_d;
            is_load_q  <= is_load_d;
            stall_q    <= stall_d;
        end
    end

    // Operand muxes sit after the register so refreshed values reach the ALU directly.
    assign alu_a       = a_sel_q ? pc_q : rs1_q;
    assign alu_b       = b_sel_q ? imm_q : rs2_q;
    assign store_data  = rs2_q;
    assign out_valid   = valid_q;
    assign alu_op_out  = op_q;
    assign rd_out      = rd_q;
    assign reg_we_out  = reg_we_q;
    assign is_load_out = is_load_q;
    assign pc_out      = pc_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_id_ex_stage;

    localparam int unsigned XLEN = 64;
    localparam int unsigned RA_W = 5;
    localparam logic [3:0] ALU_DEFAULT = 4'h0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic            in_valid, in_ready;
    logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
    logic [RA_W-1:0] rs1_addr, rs2_addr, rd_addr;
    logic [3:0]      alu_op;
    logic            a_sel, b_sel, uses_rs1, uses_rs2, reg_we, is_load;
    logic            ex_fwd_valid, ex_fwd_is_load, wb_fwd_valid;
    logic [RA_W-1:0] ex_fwd_rd, wb_fwd_rd;
    logic [XLEN-1:0] ex_fwd_data, wb_fwd_data;
    logic            flush, out_valid, out_ready;
    logic [XLEN-1:0] alu_a, alu_b, pc_out, store_data;
    logic [3:0]      alu_op_out;
    logic [RA_W-1:0] rd_out;
    logic            reg_we_out, is_load_out;
    logic [15:0]     stall_cnt;

    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .alu_op(alu_op), .a_sel(a_sel), .b_sel(b_sel),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .reg_we(reg_we), .is_load(is_load),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .ex_fwd_is_load(ex_fwd_is_load),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op_out(alu_op_out), .rd_out(rd_out),
        .reg_we_out(reg_we_out), .is_load_out(is_load_out),
        .pc_out(pc_out), .store_data(store_data), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [RA_W-1:0] rs1_addr;
        logic [RA_W-1:0] rs2_addr;
        logic [RA_W-1:0] rd;
        logic [3:0]      op;
        logic            a_sel;
        logic            b_sel;
        logic            reg_we;
        logic            is_load;
    } ent_t;

    ent_t        q[$];
    ent_t        last;
    int unsigned stall_m;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] a, input logic [XLEN-1:0] d);
        if (ex_fwd_valid && !ex_fwd_is_load && ex_fwd_rd != 0 && ex_fwd_rd == a) return ex_fwd_data;
        if (wb_fwd_valid && wb_fwd_rd != 0 && wb_fwd_rd == a) return wb_fwd_data;
        return d;
    endfunction

    function automatic bit load_use();
        return ex_fwd_valid && ex_fwd_is_load && ex_fwd_rd != 0 &&
               ((uses_rs1 && ex_fwd_rd == rs1_addr) || (uses_rs2 && ex_fwd_rd == rs2_addr));
    endfunction

    function automatic bit exp_rdy();
        return (q.size() == 0 || out_ready) && !load_use() && !flush;
    endfunction

    // Reference model: decides at each rising edge what the stage holds next.
    always @(posedge clk) begin
        bit   go;
        ent_t e;
        if (!rstn) begin
            q.delete();
            stall_m = 0;
            last    = '0;
            last.op = ALU_DEFAULT;
        end else begin
            go = in_valid && exp_rdy();
            if (in_valid && load_use() && !flush && stall_m < 65535) stall_m++;
            if (flush) begin
                q.delete();
            end else if (go) begin
                e.pc = pc; e.imm = imm; e.rd = rd_addr; e.op = alu_op;
                e.rs1_addr = rs1_addr; e.rs2_addr = rs2_addr;
                e.rs1_val = fwd(rs1_addr, rs1_data);
                e.rs2_val = fwd(rs2_addr, rs2_data);
                e.a_sel = a_sel; e.b_sel = b_sel; e.reg_we = reg_we; e.is_load = is_load;
                q.delete();
                q.push_back(e);
                last = e;
            end else if (q.size() != 0 && !out_ready) begin
                e = q[0];
                e.rs1_val = fwd(e.rs1_addr, e.rs1_val);
                e.rs2_val = fwd(e.rs2_addr, e.rs2_val);
                q[0] = e;
                last = e;
            end
        end
    end

    // Monitor: compares what the DUT presents mid-cycle and retires consumed entries.
    always @(negedge clk) begin
        ent_t c;
        c = (q.size() != 0) ? q[0] : last;
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(exp_rdy()));
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
        chk("alu_a", alu_a, c.a_sel ? c.pc : c.rs1_val);
        chk("alu_b", alu_b, c.b_sel ? c.imm : c.rs2_val);
        chk("store_data", store_data, c.rs2_val);
        chk("pc_out", pc_out, c.pc);
        chk("alu_op_out", 64'(alu_op_out), 64'(c.op));
        chk("rd_out", 64'(rd_out), 64'(c.rd));
        chk("reg_we_out", 64'(reg_we_out), 64'(c.reg_we));
        chk("is_load_out", 64'(is_load_out), 64'(c.is_load));
        if (q.size() != 0 && out_ready) void'(q.pop_front());
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rstn = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        pc = '0; rs1_data = '0; rs2_data = '0; imm = '0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0; alu_op = 4'h1;
        a_sel = 1'b0; b_sel = 1'b0; uses_rs1 = 1'b0; uses_rs2 = 1'b0;
        reg_we = 1'b0; is_load = 1'b0;
        ex_fwd_valid = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0; ex_fwd_is_load = 1'b0;
        wb_fwd_valid = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    task automatic rand_inputs();
        rstn = ($urandom_range(0, 199) != 0);
        in_valid = ($urandom_range(0, 3) != 0);
        pc = {$urandom, $urandom}; imm = {$urandom, $urandom};
        rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
        rs1_addr = RA_W'($urandom_range(0, 7)); rs2_addr = RA_W'($urandom_range(0, 7));
        rd_addr = RA_W'($urandom); alu_op = 4'($urandom);
        a_sel = 1'($urandom); b_sel = 1'($urandom);
        uses_rs1 = 1'($urandom); uses_rs2 = 1'($urandom);
        reg_we = 1'($urandom); is_load = 1'($urandom);
        ex_fwd_valid = 1'($urandom); ex_fwd_rd = RA_W'($urandom_range(0, 7));
        ex_fwd_data = {$urandom, $urandom}; ex_fwd_is_load = ($urandom_range(0, 3) == 0);
        wb_fwd_valid = 1'($urandom); wb_fwd_rd = RA_W'($urandom_range(0, 7));
        wb_fwd_data = {$urandom, $urandom};
        flush = ($urandom_range(0, 19) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        repeat (3) step();
        chk("reset_alu_op", 64'(alu_op_out), 64'(ALU_DEFAULT));
        chk("reset_valid", 64'(out_valid), 64'd0);
        rstn = 1'b1;

        // Back-to-back issue
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; pc = XLEN'(64'h100 + 4 * i);
            rs1_data = XLEN'(64'h1000 + i); rs2_data = XLEN'(64'h2000 + i);
            rs1_addr = 5'd1; rs2_addr = 5'd2; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            step();
            chk("b2b_valid", 64'(out_valid), 64'd1);
            chk("b2b_alu_a", alu_a, 64'h1000 + 64'(i));
            chk("b2b_alu_b", alu_b, 64'h2000 + 64'(i));
        end
        idle(); step();
        chk("b2b_drain", 64'(out_valid), 64'd0);

        // Forward priority
        in_valid = 1'b1; rs1_addr = 5'd5; uses_rs1 = 1'b1; rs1_data = 64'h11;
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd5; ex_fwd_data = 64'hAA;
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 64'hBB;
        step();
        chk("fwd_ex_wins", alu_a, 64'hAA);
        ex_fwd_valid = 1'b0;
        step();
        chk("fwd_wb", alu_a, 64'hBB);
        idle(); step();

        // x0 is never forwarded
        in_valid = 1'b1; rs2_addr = 5'd0; uses_rs2 = 1'b1; rs2_data = '0;
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd0; ex_fwd_data = 64'h55;
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd0; wb_fwd_data = 64'h77;
        step();
        chk("x0_alu_b", alu_b, 64'h0);
        chk("x0_store", store_data, 64'h0);
        idle(); step();

        // Load-use stall
        do_reset();
        in_valid = 1'b1; rs1_addr = 5'd7; uses_rs1 = 1'b1; rs1_data = 64'hDEAD;
        ex_fwd_valid = 1'b1; ex_fwd_is_load = 1'b1; ex_fwd_rd = 5'd7; ex_fwd_data = 64'hEE;
        #2 chk("lu_ready0", 64'(in_ready), 64'd0);
        step();
        #2 chk("lu_ready1", 64'(in_ready), 64'd0);
        step();
        chk("lu_stall_cnt", 64'(stall_cnt), 64'd2);
        chk("lu_no_capture", 64'(out_valid), 64'd0);
        ex_fwd_valid = 1'b0; ex_fwd_is_load = 1'b0;
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 64'h1234;
        #2 chk("lu_ready_clear", 64'(in_ready), 64'd1);
        step();
        chk("lu_alu_a", alu_a, 64'h1234);
        chk("lu_stall_hold", 64'(stall_cnt), 64'd2);
        idle(); step();

        // Held entry picks up late WB data
        in_valid = 1'b1; rs2_addr = 5'd3; uses_rs2 = 1'b1; rs2_data = 64'h10; out_ready = 1'b0;
        step();
        chk("held_store0", store_data, 64'h10);
        in_valid = 1'b0; wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd3; wb_fwd_data = 64'h99;
        step();
        chk("held_store1", store_data, 64'h99);
        chk("held_valid", 64'(out_valid), 64'd1);

        // Flush drops held and incoming entries
        wb_fwd_valid = 1'b0; flush = 1'b1; in_valid = 1'b1;
        rd_addr = 5'd9; alu_op = 4'h5; rs2_addr = 5'd4; rs2_data = 64'h4444;
        step();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_no_capture", store_data, 64'h99);
        idle(); step();

        // Reset in the middle of a stall discards the held entry
        in_valid = 1'b1; alu_op = 4'h7; out_ready = 1'b0;
        step();
        chk("mid_op_held", 64'(alu_op_out), 64'h7);
        rs1_addr = 5'd7; uses_rs1 = 1'b1;
        ex_fwd_valid = 1'b1; ex_fwd_is_load = 1'b1; ex_fwd_rd = 5'd7;
        step();
        rstn = 1'b0;
        step();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_op", 64'(alu_op_out), 64'(ALU_DEFAULT));
        chk("mid_rst_stall", 64'(stall_cnt), 64'd0);
        idle(); step();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rand_inputs();
            step();
        end
        idle();
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
